// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// init/run state encoding and the byte merge used by both the write path
// and the write-to-read forwarding path.
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  // Merge one byte lane: take the new byte where its mask bit is set,
  // otherwise keep the old byte. Callers loop this over every lane so the
  // word width stays a parameter of the caller.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       mask_b);
    return mask_b ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_init_fsm.sv
// Init/clear sequencer for regfile_mp. Walks every entry writing zero after
// reset or a clear request, then raises o_ready. The top level muxes the
// clear-write strobe/address against the user write port.
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  output logic              o_ready,
  output logic              o_run,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  // Sequencer: clear restarts the sweep from entry 0 in either state; the
  // last sweep edge moves to RUN and raises ready together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (i_clr) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == INIT) begin
      if (r_cnt == LAST) begin
        r_state <= RUN;
        r_cnt   <= '0;
        r_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_ready    = r_ready;
  assign o_run      = (r_state == RUN);
  assign o_clr_we   = (r_state == INIT);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-masked writes,
// registered reads and a hardware zeroing sequencer. Storage has no reset;
// READY marks when the array has been swept clean and accepts accesses.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write
// (per byte, per port) into a read of the same address; otherwise reads
// return the pre-write contents.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        W_ADDR,
  input  logic [DATA_W-1:0]        W_DATA,
  input  logic [DATA_W/8-1:0]      W_MASK,
  input  logic [NUM_RD*ADDR_W-1:0] R_ADDR,
  output logic [NUM_RD*DATA_W-1:0] OUT,
  output logic                     READY
);

  localparam int MB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_ok;
  logic              w_usr_we;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_word;
  logic [NUM_RD*DATA_W-1:0] w_rd_all;

  regfile_init_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_fsm (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clr      (CLR),
    .o_ready    (w_ready),
    .o_run      (w_run),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // A user write lands only in RUN, in range, off the hardwired zero entry,
  // and never in a cycle where a clear request wins.
  assign w_wr_ok  = ({1'b0, W_ADDR} < DEPTH_L) && !((ZERO_REG != 0) && (W_ADDR == '0));
  assign w_usr_we = w_run && RegWrite && !CLR && w_wr_ok;
  assign w_wr_old = r_mem[W_ADDR[IDX_W-1:0]];

  // Read-modify-write merge of the selected byte lanes into the old word.
  always_comb begin
    w_wr_word = w_wr_old;
    for (int b = 0; b < MB; b++) begin
      w_wr_word[8*b +: 8] = byte_merge(w_wr_old[8*b +: 8], W_DATA[8*b +: 8], W_MASK[b]);
    end
  end

  // Storage: the sequencer's zeroing sweep and the user port never overlap
  // because one needs INIT and the other RUN.
  always_ff @(posedge CLK) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr[IDX_W-1:0]] <= '0;
    end else if (w_usr_we) begin
      r_mem[W_ADDR[IDX_W-1:0]] <= w_wr_word;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rd_raw;
    logic [DATA_W-1:0] w_rd_word;

    assign w_raddr  = R_ADDR[p*ADDR_W +: ADDR_W];
    assign w_rd_ok  = ({1'b0, w_raddr} < DEPTH_L) && !((ZERO_REG != 0) && (w_raddr == '0));
    assign w_rd_raw = r_mem[w_raddr[IDX_W-1:0]];

`ifdef REGFILE_BYPASS_EN
    // Forward the lanes being written this cycle into a matching read.
    always_comb begin
      w_rd_word = w_rd_raw;
      if (w_usr_we && (W_ADDR == w_raddr)) begin
        for (int b = 0; b < MB; b++) begin
          w_rd_word[8*b +: 8] = byte_merge(w_rd_raw[8*b +: 8], W_DATA[8*b +: 8], W_MASK[b]);
        end
      end
    end
`else
    // Read-before-write: a same-cycle write shows up one cycle later.
    assign w_rd_word = w_rd_raw;
`endif

    // Zero-entry and out-of-range masking sits after forwarding so it wins.
    assign w_rd_all[p*DATA_W +: DATA_W] = w_rd_ok ? w_rd_word : '0;
  end

  // Registered read data, forced to zero while the array is being swept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT <= '0;
    end else if (w_run) begin
      OUT <= w_rd_all;
    end else begin
      OUT <= '0;
    end
  end

  assign READY = w_ready;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, successor to the fixed 32×64 dual-read design: configurable width, depth and read-port count, byte-masked writes, registered reads and a hardware init/clear sequencer. It holds architectural operands for the datapath. Storage is memory-style with no per-entry reset; contents are zeroed by an internal state machine after reset or on request, and `READY` gates use.

## Interface
- `DATA_W`, 64, word width; must be a multiple of 8.
- `ADDR_W`, 5, address width.
- `DEPTH`, 32, number of entries; must satisfy DEPTH ≤ 2^ADDR_W.
- `NUM_RD`, 2, number of read ports (1–4).
- `ZERO_REG`, 1, when 1 entry 0 reads as zero and ignores writes.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `CLR`  in  1  synchronous soft-clear request, one-cycle pulse.
- `RegWrite`  in  1  write enable.
- `W_ADDR`  in  ADDR_W  write address.
- `W_DATA`  in  DATA_W  write data.
- `W_MASK`  in  DATA_W/8  byte enables; bit i covers `W_DATA[8i+7:8i]`.
- `R_ADDR`  in  NUM_RD*ADDR_W  packed read addresses; port p is `[p*ADDR_W +: ADDR_W]`.
- `OUT`  out  NUM_RD*DATA_W  packed registered read data; port p is `[p*DATA_W +: DATA_W]`.
- `READY`  out  1  high when the array is initialised and accepting accesses.

## Operation
- FSM states: INIT and RUN.
- `RST` asserted: state INIT, clear counter 0, `READY`=0, `OUT`=0.
- INIT behaviour, per edge:
  - writes `mem[cnt]` = 0 and increments `cnt`;
  - at `cnt`==DEPTH-1 transitions to RUN on the same edge.
  - `RegWrite` is ignored; `OUT` is held at 0.
- RUN behaviour, per edge:
  - if `RegWrite` is set and the address is in range, the selected bytes are merged: `mem[W_ADDR]` = (old & ~mask) | (`W_DATA` & mask).
  - `W_MASK`=0 leaves the entry unchanged.
- Each read port registers `mem[R_ADDR_p]` into `OUT_p` every RUN cycle.
- Address ≥ DEPTH: write dropped, read returns 0.
- `ZERO_REG`=1: write to address 0 dropped; address 0 always reads 0.
- `CLR` behaviour:
  - in RUN: the FSM moves to INIT, `cnt`=0 and `READY` falls on the next edge.
  - in INIT: restarts `cnt` at 0.
  - `CLR` and `RegWrite` in the same cycle: `CLR` wins and the write is dropped.
- `RST` mid-INIT or mid-RUN forces INIT from address 0 immediately, asynchronously.
- Multiple read ports addressing the same entry all return identical data.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on `OUT` after edge N.
- Write latency: data written at edge N is visible on `OUT` from a read sampled at edge N+1.
- Same-cycle read/write collision behaviour depends on the build (see Configuration).
- `READY` rises exactly DEPTH edges after `RST` deasserts or after the edge sampling `CLR`.
- `READY` and `OUT` are glitch-free register outputs.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read that hits the address being written in the same RUN cycle returns the merged new word (write-to-read forwarding). This applies per port and per byte, according to the mask.
- `REGFILE_BYPASS_EN` undefined: the read returns the pre-write contents (read-before-write); the new value is visible one cycle later.
- `ZERO_REG` and out-of-range rules take precedence over bypass in both builds.

## Structure
- `regfile_pkg` holds:
  - the default `DATA_W`/`ADDR_W`/`DEPTH` constants;
  - the state enum (INIT, RUN);
  - a byte-mask merge function `(old, new, mask)` shared by the write path and the bypass path.
- Sub-module `regfile_init_fsm` owns state, `cnt`, `READY` and the clear-write strobe/address. The top level muxes the clear-write strobe/address against the user write port.

## Test plan
- Reset release, DEPTH=32: `READY` is 0 for 32 edges, then 1; read of all addresses returns 0.
- Full-mask writes: write `i+65536` to addresses 1..31, then read on both ports. Expect `i+65536`; address 0 returns 0 after a write of 64'hFFFF with `ZERO_REG`=1.
- Partial mask: address 5 holds 64'h1111_2222_3333_4444; write 64'hFFFF_FFFF_FFFF_FFFF with `W_MASK`=8'h0F. Readback must be 64'h1111_2222_FFFF_FFFF.
- Collision: write 25 to address 5 while both ports read 5. With bypass the next `OUT` is 25; without bypass it is the old value, and 25 appears one cycle later.
- `CLR` mid-RUN with a simultaneous write to address 7:
  - `READY` drops next edge and the write is lost;
  - after 32 edges all reads return 0;
  - `RST` pulsed at clear count 10 restarts the 32-edge INIT.
- NUM_RD=4, DEPTH=20: reading address 25 returns 0 and writing address 25 has no effect; ports reading 3, 3, 19 and 0 return consistent data.
